// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants, types and helpers for the multiplexed
// 7-segment display scanner.
//   SUB_TICKS    : sub-ticks per digit slot
//   MAX_DIGITS   : widest supported digit count (width of ENB_ALL_OFF)
//   phase_e      : per-slot phase decoded from the sub-tick count
//   ENB_ALL_OFF  : all common-node enables inactive (active-low, so all ones)
//   decode_phase : sub-tick count + brightness -> slot phase
package seg_disp_pkg;

   localparam int unsigned SUB_TICKS  = 16;
   localparam int unsigned MAX_DIGITS = 16;

   typedef enum logic [1:0] {
      GUARD,
      ON,
      OFF
   } phase_e;

   function automatic logic [MAX_DIGITS-1:0] ENB_ALL_OFF();
      return '1;
   endfunction

   // Sub-tick 0 is always a blank guard; the following 'bright' sub-ticks light.
   function automatic phase_e decode_phase(input logic [3:0] sub, input logic [3:0] bright);
      if (sub == 4'd0)
         return GUARD;
      else if (sub <= bright)
         return ON;
      else
         return OFF;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running clock divider producing the scan sub-tick.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   tick_o : high for one cycle while the divider sits at TICK_DIV-1
module scan_tick_gen #(
   parameter int unsigned TICK_DIV = 5000
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   always_comb begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_W'(TICK_DIV - 1))
         div_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_q <= '0;
      else
         div_q <= div_d;
   end

   assign tick_o = (div_q == DIV_W'(TICK_DIV - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with per-digit blink,
// guard blanking at every digit change and 16-level PWM brightness.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   i_digit_seg  : segment patterns, digit d at [d*SEG_W +: SEG_W], digit 0 rightmost
//   i_dp         : decimal point per digit
//   i_blink_mask : 1 = digit blinks
//   i_blink_sync : one-cycle pulse, forces blink phase visible and restarts count
//   i_bright     : lit sub-ticks per slot (0 = dark, 15 = max)
//   o_seg        : segment pattern of the active digit (registered)
//   o_seg_dp     : decimal point of the active digit (registered)
//   o_seg_enb    : common-node enables, active-low, at most one low (registered)
//   o_frame      : one-cycle pulse at each frame wrap (registered)
module seg_scan_ctrl
   import seg_disp_pkg::*;
#(
   parameter int unsigned N_DIGITS     = 6,
   parameter int unsigned SEG_W        = 7,
   parameter int unsigned TICK_DIV     = 5000,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_DIGITS*SEG_W-1:0] i_digit_seg,
   input  logic [N_DIGITS-1:0]       i_dp,
   input  logic [N_DIGITS-1:0]       i_blink_mask,
   input  logic                      i_blink_sync,
   input  logic [3:0]                i_bright,
   output logic [SEG_W-1:0]          o_seg,
   output logic                      o_seg_dp,
   output logic [N_DIGITS-1:0]       o_seg_enb,
   output logic                      o_frame
);

   localparam int unsigned DIG_W = $clog2(N_DIGITS);
   localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic tick;

   scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   logic [3:0]          sub_q,   sub_d;
   logic [DIG_W-1:0]    dig_q,   dig_d;
   logic [FC_W-1:0]     fcnt_q,  fcnt_d;
   logic                blink_q, blink_d;
   logic                prime_q, prime_d;
   logic [SEG_W-1:0]    seg_sh_q,  seg_sh_d;
   logic                dp_sh_q,   dp_sh_d;
   logic                mask_sh_q, mask_sh_d;
   logic [SEG_W-1:0]    seg_q,   seg_d;
   logic                dp_q,    dp_d;
   logic [N_DIGITS-1:0] enb_q,   enb_d;
   logic                frame_q, frame_d;

   logic       slot_wrap;
   logic       frame_wrap;
   logic       capture;
   logic [DIG_W-1:0] cap_dig;
   phase_e     phase;

   always_comb begin
      sub_d     = sub_q;
      dig_d     = dig_q;
      fcnt_d    = fcnt_q;
      blink_d   = blink_q;
      prime_d   = 1'b0;
      seg_sh_d  = seg_sh_q;
      dp_sh_d   = dp_sh_q;
      mask_sh_d = mask_sh_q;

      slot_wrap  = tick && (sub_q == 4'(SUB_TICKS - 1));
      frame_wrap = slot_wrap && (dig_q == DIG_W'(N_DIGITS - 1));

      if (tick)
         sub_d = sub_q + 1'b1;
      if (slot_wrap)
         dig_d = (dig_q == DIG_W'(N_DIGITS - 1)) ? '0 : dig_q + 1'b1;

      // The first slot after reset is never entered by a wrap, so prime_q
      // loads digit 0's shadow on the first cycle out of reset instead.
      capture = slot_wrap || prime_q;
      cap_dig = slot_wrap ? dig_d : dig_q;
      if (capture) begin
         for (int unsigned d = 0; d < N_DIGITS; d++) begin
            if (cap_dig == DIG_W'(d)) begin
               seg_sh_d  = i_digit_seg[d*SEG_W +: SEG_W];
               dp_sh_d   = i_dp[d];
               mask_sh_d = i_blink_mask[d];
            end
         end
      end

      // Sync overrides a toggle landing on the same edge.
      if (i_blink_sync) begin
         blink_d = 1'b0;
         fcnt_d  = '0;
      end else if (frame_wrap) begin
         if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      // Outputs lag the counters by one cycle, so the segment bus only
      // changes while the enables already show the guard blank.
      phase   = decode_phase(sub_q, i_bright);
      seg_d   = seg_sh_q;
      dp_d    = dp_sh_q;
      frame_d = frame_wrap;
      enb_d   = N_DIGITS'(ENB_ALL_OFF());
      if (phase == ON && !(blink_q && mask_sh_q)) begin
         for (int unsigned d = 0; d < N_DIGITS; d++) begin
            if (dig_q == DIG_W'(d))
               enb_d[d] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_q     <= '0;
         dig_q     <= '0;
         fcnt_q    <= '0;
         blink_q   <= 1'b0;
         prime_q   <= 1'b1;
         seg_sh_q  <= '0;
         dp_sh_q   <= 1'b0;
         mask_sh_q <= 1'b0;
         seg_q     <= '0;
         dp_q      <= 1'b0;
         enb_q     <= '1;
         frame_q   <= 1'b0;
      end else begin
         sub_q     <= sub_d;
         dig_q     <= dig_d;
         fcnt_q    <= fcnt_d;
         blink_q   <= blink_d;
         prime_q   <= prime_d;
         seg_sh_q  <= seg_sh_d;
         dp_sh_q   <= dp_sh_d;
         mask_sh_q <= mask_sh_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         enb_q     <= enb_d;
         frame_q   <= frame_d;
      end
   end

   assign o_seg     = seg_q;
   assign o_seg_dp  = dp_q;
   assign o_seg_enb = enb_q;
   assign o_frame   = frame_q;

endmodule
